// File: rtl/nios_mtl_sysid_pkg.sv
// Shared types and constants for the system-ID sequencer/arbiter.
package nios_mtl_sysid_pkg;

  typedef enum logic [2:0] {
    BOOT_ID,
    BOOT_WAIT_ID,
    BOOT_WAIT_TS,
    IDLE,
    WAIT
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam int MAX_N_REQ = 8;

endpackage

// File: rtl/nios_mtl_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from ptr+1, with wrap.
module nios_mtl_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] win_onehot,
  output logic [IDX_W-1:0] win_idx
);

  logic [IDX_W-1:0] cand_idx;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    cand_idx   = '0;
    // Walk from farthest to nearest so the nearest set bit after ptr is the last one written.
    for (int i = N_REQ; i >= 1; i--) begin
      cand_idx = IDX_W'((int'(ptr) + i) % N_REQ);
      if (req[cand_idx]) begin
        win_onehot           = '0;
        win_onehot[cand_idx] = 1'b1;
        win_idx              = cand_idx;
      end
    end
  end

endmodule

// File: rtl/nios_mtl_sysid_ctrl.sv
// Boot-time hardware/software ID check followed by round-robin sharing of the system-ID slave.
module nios_mtl_sysid_ctrl
  import nios_mtl_sysid_pkg::*;
#(
  parameter int          N_REQ         = 2,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [31:0] EXPECTED_ID   = 32'd1461078904,
  parameter logic [31:0] EXPECTED_TS   = 32'd0,
  parameter bit          CHECK_TS      = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_addr,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] rvalid,
  output logic [31:0]      rdata,
  output logic             sysid_address,
  input  logic [31:0]      sysid_readdata,
  output logic             check_done,
  output logic             id_match,
  output logic             ts_match,
  output logic             busy
);

  localparam int         IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [2:0] LAST_CNT = 3'(SETTLE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] rvalid_q, rvalid_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             addr_q, addr_d;
  logic             check_done_q, check_done_d;
  logic             id_match_q, id_match_d;
  logic             ts_match_q, ts_match_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0] win_onehot;
  logic [IDX_W-1:0] win_idx;

  nios_mtl_rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (req),
    .ptr        (ptr_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    gnt_d        = '0;
    rvalid_d     = '0;
    rdata_d      = rdata_q;
    addr_d       = addr_q;
    check_done_d = check_done_q;
    id_match_d   = id_match_q;
    ts_match_d   = ts_match_q;

    unique case (state_q)
      BOOT_ID: begin
        addr_d  = SYSID_ADDR_ID;
        cnt_d   = '0;
        state_d = BOOT_WAIT_ID;
      end
      BOOT_WAIT_ID: begin
        if (cnt_q == LAST_CNT) begin
          id_match_d = (sysid_readdata == EXPECTED_ID);
          addr_d     = SYSID_ADDR_TS;
          cnt_d      = '0;
          state_d    = BOOT_WAIT_TS;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      BOOT_WAIT_TS: begin
        if (cnt_q == LAST_CNT) begin
          ts_match_d   = !CHECK_TS || (sysid_readdata == EXPECTED_TS);
          check_done_d = 1'b1;
          cnt_d        = '0;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      IDLE: begin
        if (|req) begin
          gnt_d   = win_onehot;
          addr_d  = req_addr[win_idx];
          ptr_d   = win_idx;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // ptr_q still names the requester whose read is in flight.
        if (cnt_q == LAST_CNT) begin
          rdata_d         = sysid_readdata;
          rvalid_d[ptr_q] = 1'b1;
          state_d         = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = BOOT_ID;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= BOOT_ID;
      cnt_q        <= '0;
      ptr_q        <= IDX_W'(N_REQ - 1);
      gnt_q        <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
      addr_q       <= SYSID_ADDR_ID;
      check_done_q <= 1'b0;
      id_match_q   <= 1'b0;
      ts_match_q   <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      addr_q       <= addr_d;
      check_done_q <= check_done_d;
      id_match_q   <= id_match_d;
      ts_match_q   <= ts_match_d;
      busy_q       <= busy_d;
    end
  end

  assign gnt           = gnt_q;
  assign rvalid        = rvalid_q;
  assign rdata         = rdata_q;
  assign sysid_address = addr_q;
  assign check_done    = check_done_q;
  assign id_match      = id_match_q;
  assign ts_match      = ts_match_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_nios_mtl_sysid_ctrl.sv
// Directed bench: boot check, single reads, round-robin order, reset abort, early-dropped request.
module tb_nios_mtl_sysid_ctrl;

  localparam logic [31:0] ID_WORD = 32'd1461078904;
  localparam logic [31:0] TS_WORD = 32'h5F3A_1C20;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req, req_addr;
  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata;
  logic        sysid_address;
  logic [31:0] sysid_readdata;
  logic        check_done, id_match, ts_match, busy;

  logic [1:0]  req2, req_addr2;
  logic [1:0]  gnt2, rvalid2;
  logic [31:0] rdata2;
  logic        addr2;
  logic [31:0] readdata2;
  logic        check_done2, id_match2, ts_match2, busy2;

  logic [31:0] id_val, ts_val, ts2_val;
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clock = ~clock;

  // Combinational system-ID slaves.
  assign sysid_readdata = sysid_address ? ts_val  : id_val;
  assign readdata2      = addr2         ? ts2_val : id_val;

  nios_mtl_sysid_ctrl #(
    .N_REQ         (2),
    .SETTLE_CYCLES (1),
    .EXPECTED_ID   (ID_WORD),
    .EXPECTED_TS   (TS_WORD),
    .CHECK_TS      (1'b1)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req            (req),
    .req_addr       (req_addr),
    .gnt            (gnt),
    .rvalid         (rvalid),
    .rdata          (rdata),
    .sysid_address  (sysid_address),
    .sysid_readdata (sysid_readdata),
    .check_done     (check_done),
    .id_match       (id_match),
    .ts_match       (ts_match),
    .busy           (busy)
  );

  // Slower settle and timestamp check disabled, fed a timestamp that does not match.
  nios_mtl_sysid_ctrl #(
    .N_REQ         (2),
    .SETTLE_CYCLES (2),
    .CHECK_TS      (1'b0)
  ) dut2 (
    .clock          (clock),
    .reset          (reset),
    .req            (req2),
    .req_addr       (req_addr2),
    .gnt            (gnt2),
    .rvalid         (rvalid2),
    .rdata          (rdata2),
    .sysid_address  (addr2),
    .sysid_readdata (readdata2),
    .check_done     (check_done2),
    .id_match       (id_match2),
    .ts_match       (ts_match2),
    .busy           (busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_gnt",        32'(gnt),           32'd0);
    check("rst_rvalid",     32'(rvalid),        32'd0);
    check("rst_rdata",      rdata,              32'd0);
    check("rst_addr",       32'(sysid_address), 32'd0);
    check("rst_check_done", 32'(check_done),    32'd0);
    check("rst_id_match",   32'(id_match),      32'd0);
    check("rst_ts_match",   32'(ts_match),      32'd0);
    check("rst_busy",       32'(busy),          32'd1);
  endtask

  // Three edges after reset release check_done rises; no grant or rvalid before that.
  task automatic boot_seq(input logic exp_id);
    for (int e = 1; e <= 3; e++) begin
      tick();
      check("boot_done",   32'(check_done), (e == 3) ? 32'd1 : 32'd0);
      check("boot_gnt",    32'(gnt),        32'd0);
      check("boot_rvalid", 32'(rvalid),     32'd0);
    end
    check("boot_id_match", 32'(id_match), 32'(exp_id));
    check("boot_ts_match", 32'(ts_match), 32'd1);
    check("boot_busy",     32'(busy),     32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    req       = 2'b00;
    req_addr  = 2'b10;
    req2      = 2'b00;
    req_addr2 = 2'b00;
    id_val    = ID_WORD;
    ts_val    = TS_WORD;
    ts2_val   = 32'hDEAD_BEEF;

    // Reset values and boot timing for both instances.
    tick();
    tick();
    check_reset_vals();
    reset = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check("boot1_done", 32'(check_done),  (e >= 3) ? 32'd1 : 32'd0);
      check("boot1_gnt",  32'(gnt),         32'd0);
      check("boot2_done", 32'(check_done2), (e >= 5) ? 32'd1 : 32'd0);
    end
    check("boot1_id_match", 32'(id_match),  32'd1);
    check("boot1_ts_match", 32'(ts_match),  32'd1);
    check("boot2_id_match", 32'(id_match2), 32'd1);
    check("boot2_ts_forced", 32'(ts_match2), 32'd1);
    check("boot1_busy",     32'(busy),      32'd0);

    // Single read: requester 0 reads the ID word.
    req = 2'b01;
    tick();
    check("rd0_gnt",    32'(gnt),           32'h1);
    check("rd0_addr",   32'(sysid_address), 32'd0);
    check("rd0_busy",   32'(busy),          32'd1);
    check("rd0_rv_lo",  32'(rvalid),        32'd0);
    tick();
    check("rd0_rvalid", 32'(rvalid),        32'h1);
    check("rd0_rdata",  rdata,              ID_WORD);
    check("rd0_gnt_lo", 32'(gnt),           32'd0);
    req = 2'b00;
    tick();
    check("idle_gnt",    32'(gnt),    32'd0);
    check("idle_rvalid", 32'(rvalid), 32'd0);
    check("idle_rdata",  rdata,       ID_WORD);

    // Slave ID reads as zero: mismatch reported.
    id_val = 32'd0;
    apply_reset();
    boot_seq(1'b0);
    id_val = ID_WORD;

    // Fresh pointer, both requesting continuously: order 0,1,0,1.
    apply_reset();
    boot_seq(1'b1);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_gnt",       32'(gnt),           32'(2'b01 << (k % 2)));
      check("rr_addr",      32'(sysid_address), 32'(k % 2));
      check("rr_rv_lo",     32'(rvalid),        32'd0);
      tick();
      check("rr_rvalid",    32'(rvalid),        32'(2'b01 << (k % 2)));
      check("rr_rdata",     rdata,              (k % 2 == 1) ? TS_WORD : ID_WORD);
      check("rr_gnt_lo",    32'(gnt),           32'd0);
    end
    req = 2'b00;
    tick();

    // Reset during WAIT aborts the read; the still-held request is served after reboot.
    req = 2'b01;
    tick();
    check("abort_gnt", 32'(gnt), 32'h1);
    reset = 1'b1;
    #1;
    check_reset_vals();
    tick();
    check("abort_no_rvalid", 32'(rvalid), 32'd0);
    reset = 1'b0;
    boot_seq(1'b1);
    tick();
    check("abort_regnt",  32'(gnt),    32'h1);
    tick();
    check("abort_rvalid", 32'(rvalid), 32'h1);
    check("abort_rdata",  rdata,       ID_WORD);
    req = 2'b00;

    // Request raised during boot, dropped right after its grant.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    req   = 2'b10;
    boot_seq(1'b1);
    tick();
    check("drop_gnt",  32'(gnt),           32'h2);
    check("drop_addr", 32'(sysid_address), 32'd1);
    req = 2'b00;
    tick();
    check("drop_rvalid", 32'(rvalid), 32'h2);
    check("drop_rdata",  rdata,       TS_WORD);
    for (int e = 0; e < 2; e++) begin
      tick();
      check("drop_no_regnt",  32'(gnt),    32'd0);
      check("drop_rv_once",   32'(rvalid), 32'd0);
    end
    check("drop_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
